demux_slot_scheduler: RTL and testbench

- Time-slot scheduler that sequences the 1-to-8 demux (`demux_1to8`). It picks enabled output channels in round-robin order and holds each one for a programmable dwell.
- During a slot it accepts input bits through a valid/ready handshake and presents them, registered, to the demux `din`/`sel` inputs with a qualifying strobe.
- Sits directly upstream of `demux_1to8`: `sel` and `din` drive it; `dout_valid` qualifies its outputs.

---
 rtl/demux_sched_pkg.sv | 17 +
 rtl/rr_next_ch.sv | 40 ++++
 rtl/demux_slot_scheduler.sv | 108 ++++++++++
 tb/tb_demux_slot_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_sched_pkg.sv
// Shared types and constants for the demux slot scheduler.
// Channel count, select width, dwell width and FSM state encoding.
package demux_sched_pkg;

    localparam int NCH     = 8;
    localparam int SELW    = $clog2(NCH);
    localparam int DWELL_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SEEK,
        DWELL
    } state_t;

    typedef logic [SELW-1:0] ch_t;

endpackage

// File: rtl/rr_next_ch.sv
// Rotating-priority finder: first set mask bit at or after start.
// Ports: mask, start -> next index, found, wrapped (next <= start-1 mod NCH).
module rr_next_ch
    import demux_sched_pkg::*;
(
    input  logic [NCH-1:0] mask,
    input  ch_t            start,
    output ch_t            next,
    output logic           found,
    output logic           wrapped
);

    logic [2*NCH-1:0] dbl;
    logic [2*NCH-1:0] shifted;
    logic [NCH-1:0]   rot;
    ch_t              off;

    // Doubling the mask lets a plain shift perform the rotation.
    assign dbl     = {mask, mask};
    assign shifted = dbl >> start;
    assign rot     = shifted[NCH-1:0];

    always_comb begin
        off   = '0;
        found = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off   = ch_t'(i);
                found = 1'b1;
            end
        end
    end

    // NCH is a power of two, so the SELW-bit add wraps modulo NCH.
    assign next = start + off;

    // start==0 means the previous channel was NCH-1: any hit wraps.
    assign wrapped = found && ((start == '0) || (next < start));

endmodule

// File: rtl/demux_slot_scheduler.sv
// Round-robin time-slot scheduler feeding a 1-to-8 demux (sel/din).
// Ports: clk, rst_n, en, ch_mask, dwell, in_valid/in_data/in_ready, sel, din, dout_valid, busy, wrap.
module demux_slot_scheduler
    import demux_sched_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NCH-1:0]     ch_mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               in_valid,
    input  logic               in_data,
    output logic               in_ready,
    output ch_t                sel,
    output logic               din,
    output logic               dout_valid,
    output logic               busy,
    output logic               wrap
);

    state_t             state;
    state_t             state_nx;
    ch_t                cur_ch;
    ch_t                last_ch;
    ch_t                start_ch;
    ch_t                rr_ch;
    logic               rr_found;
    logic               rr_wrapped;
    logic               load;
    logic               acc;
    logic [DWELL_W-1:0] cnt;

    assign start_ch = last_ch + 1'b1;

    rr_next_ch u_rr (
        .mask    (ch_mask),
        .start   (start_ch),
        .next    (rr_ch),
        .found   (rr_found),
        .wrapped (rr_wrapped)
    );

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        busy     = 1'b0;
        wrap     = 1'b0;
        load     = 1'b0;
        unique case (state)
            IDLE: begin
                if (en && (ch_mask != '0)) begin
                    state_nx = SEEK;
                end
            end
            SEEK: begin
                busy = 1'b1;
                if (rr_found) begin
                    load     = 1'b1;
                    wrap     = rr_wrapped;
                    state_nx = DWELL;
                end else begin
                    state_nx = IDLE;
                end
            end
            DWELL: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (cnt == '0) begin
                    state_nx = en ? SEEK : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign acc = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cur_ch  <= '0;
            last_ch <= ch_t'(NCH - 1);
            cnt     <= '0;
        end else begin
            state <= state_nx;
            if (load) begin
                cur_ch  <= rr_ch;
                last_ch <= rr_ch;
                cnt     <= dwell;
            end else if ((state == DWELL) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel        <= '0;
            din        <= 1'b0;
            dout_valid <= 1'b0;
        end else begin
            sel        <= cur_ch;
            din        <= acc ? in_data : 1'b0;
            dout_valid <= acc;
        end
    end

endmodule

// File: tb/tb_demux_slot_scheduler.sv
// Self-checking bench for demux_slot_scheduler.
// Hand tables, directed corner sequences and a random run against a slot model.
module tb_demux_slot_scheduler;
    import demux_sched_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] ch_mask = '0;
    logic [3:0] dwell = '0;
    logic       in_valid = 1'b0;
    logic       in_data = 1'b0;
    logic       in_ready;
    logic [2:0] sel;
    logic       din;
    logic       dout_valid;
    logic       busy;
    logic       wrap;

    demux_slot_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .ch_mask    (ch_mask),
        .dwell      (dwell),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .sel        (sel),
        .din        (din),
        .dout_valid (dout_valid),
        .busy       (busy),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // model: mode 0 idle, 1 seek, 2 in slot
    int m_mode, m_ch, m_last, m_left;
    int m_sel, m_din, m_dv;

    logic smp_busy, smp_rdy, smp_wrap, smp_dv, smp_din;
    int   smp_sel;

    typedef struct {
        logic busy;
        logic rdy;
        logic wrap;
        int   sel;
        logic dv;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int find_next(input logic [7:0] m, input int last);
        for (int k = 1; k <= 8; k++) begin
            if (m[(last + k) % 8]) return (last + k) % 8;
        end
        return -1;
    endfunction

    task automatic m_reset();
        m_mode = 0;
        m_ch   = 0;
        m_last = 7;
        m_left = 0;
        m_sel  = 0;
        m_din  = 0;
        m_dv   = 0;
    endtask

    // Called at a negedge with inputs already set; returns at next negedge.
    task automatic step();
        int idx;
        int acc;
        #1;
        idx = find_next(ch_mask, m_last);
        smp_busy = busy;
        smp_rdy  = in_ready;
        smp_wrap = wrap;
        chk("busy", busy, m_mode != 0);
        chk("in_ready", in_ready, m_mode == 2);
        chk("wrap", wrap, (m_mode == 1) && (idx >= 0) && (idx <= m_last));
        @(posedge clk);
        acc   = ((m_mode == 2) && in_valid) ? 1 : 0;
        m_sel = m_ch;
        m_din = acc ? int'(in_data) : 0;
        m_dv  = acc;
        case (m_mode)
            0: if (en && ch_mask != 0) m_mode = 1;
            1: begin
                if (idx >= 0) begin
                    m_ch   = idx;
                    m_last = idx;
                    m_left = int'(dwell) + 1;
                    m_mode = 2;
                end else begin
                    m_mode = 0;
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) m_mode = en ? 1 : 0;
            end
        endcase
        #1;
        smp_sel = int'(sel);
        smp_dv  = dout_valid;
        smp_din = din;
        chk("sel", sel, m_sel);
        chk("din", din, m_din);
        chk("dout_valid", dout_valid, m_dv);
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-cycle, released on a negedge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_sel", sel, 0);
        chk("rst_din", din, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wrap", wrap, 0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_slot(input int ch);
        int n = 0;
        while (!(m_mode == 2 && m_ch == ch) && n < 100) begin
            step();
            n++;
        end
        chk("wait_slot_timeout", n < 100, 1);
    endtask

    vec_t tbl[8];
    int   cnt_a;
    int   cnt_b;
    int   beats[$];

    initial begin
        tbl[0] = '{1'b0, 1'b0, 1'b0, 0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 0, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 2, 1'b1};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 2, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 5, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 5, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 2, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 2, 1'b0};

        m_reset();
        @(negedge clk);
        do_reset();

        // sparse mask 2,5 with dwell 0, hand table
        en = 1'b1; ch_mask = 8'h24; dwell = 4'd0;
        in_valid = 1'b1; in_data = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("tbl_busy", smp_busy, tbl[i].busy);
            chk("tbl_rdy", smp_rdy, tbl[i].rdy);
            chk("tbl_wrap", smp_wrap, tbl[i].wrap);
            chk("tbl_sel", smp_sel, tbl[i].sel);
            chk("tbl_dv", smp_dv, tbl[i].dv);
        end

        // sparse mask 2,5,7: never strobe an unmasked channel
        ch_mask = 8'b1010_0100;
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (smp_dv && !ch_mask[smp_sel]) cnt_a++;
            if (smp_wrap) cnt_b++;
        end
        chk("sparse_bad_sel", cnt_a, 0);
        chk("sparse_wraps", cnt_b, 4);

        // full rotation, dwell 1
        do_reset();
        ch_mask = 8'hFF; dwell = 4'd1;
        beats = {};
        cnt_b = 0;
        for (int i = 0; i < 60 && beats.size() < 16; i++) begin
            step();
            if (smp_wrap) cnt_b++;
            if (smp_dv) beats.push_back(smp_sel);
        end
        chk("rot_beats", beats.size(), 16);
        for (int i = 0; i < beats.size(); i++) chk("rot_order", beats[i], i / 2);
        chk("rot_wraps", cnt_b, 1);
        step();
        chk("rot_wrap_7to0", smp_wrap, 1);

        // backpressure: one channel, 4-cycle slot, valid 1,0,1,1
        do_reset();
        ch_mask = 8'h01; dwell = 4'd3;
        in_valid = 1'b0;
        step();
        step();
        cnt_a = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = (i != 1);
            in_data  = (i != 2);
            step();
            if (smp_dv) cnt_a++;
        end
        chk("bp_strobes", cnt_a, 3);
        step();
        chk("bp_slot_end_busy", smp_busy, 1);
        chk("bp_slot_end_rdy", smp_rdy, 0);
        chk("bp_single_wrap", smp_wrap, 1);

        // mask and en dropped during ch3's slot
        do_reset();
        ch_mask = 8'hFF; dwell = 4'd3; in_valid = 1'b1; in_data = 1'b1;
        wait_slot(3);
        step();
        ch_mask = 8'h00; en = 1'b0;
        cnt_a = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (smp_rdy) cnt_a++;
        end
        chk("mid_slot_rdy_cycles", cnt_a, 3);
        cnt_b = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (smp_dv) cnt_b++;
            if (smp_busy) cnt_b++;
        end
        chk("mid_idle_quiet", cnt_b, 0);

        // async reset in ch5's slot, then restart at ch0
        en = 1'b1; ch_mask = 8'hFF;
        do_reset();
        wait_slot(5);
        step();
        do_reset();
        step();
        step();
        chk("restart_wrap", smp_wrap, 1);
        step();
        chk("restart_rdy", smp_rdy, 1);
        chk("restart_sel", smp_sel, 0);

        // mask FF -> 10 during ch1's slot
        do_reset();
        ch_mask = 8'hFF; dwell = 4'd2;
        wait_slot(1);
        step();
        ch_mask = 8'h10;
        step();
        step();
        for (int r = 0; r < 3; r++) begin
            step();
            chk("mu_seek_rdy", smp_rdy, 0);
            chk("mu_wrap", smp_wrap, r != 0);
            for (int i = 0; i < 3; i++) begin
                step();
                chk("mu_sel", smp_sel, 4);
                chk("mu_dv", smp_dv, 1);
            end
        end

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 24) == 0) begin
                case ($urandom_range(0, 3))
                    0: ch_mask = 8'h00;
                    1: ch_mask = 8'(1 << $urandom_range(0, 7));
                    default: ch_mask = 8'($urandom);
                endcase
            end
            if ($urandom_range(0, 29) == 0) begin
                dwell = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 499) == 0) do_reset();
            else step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
